// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with a small byte FIFO,
//            sitting beside data memory on a single-cycle core's data port.
// Revision : 1.0
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] ra,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] C_BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [1:0]    C_SEL_TXDATA = 2'd0;
    localparam logic [1:0]    C_SEL_STATUS = 2'd1;
    localparam logic [1:0]    C_SEL_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_tx;
    logic            w_tx_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic [BW-1:0]   r_baud;
    logic [BW-1:0]   w_baud_next;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_next;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_enable;

    logic [1:0]      w_sel;
    logic            w_wr;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic            w_ctrl_wr;
    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic            w_can_pop;
    logic            w_baud_done;
    logic [7:0]      w_head;
    logic [3:0]      w_count4;
    logic            w_unused;

    assign hit         = (ra[31:4] == BASE_ADDR[31:4]);
    assign w_sel       = ra[3:2];
    assign w_wr        = we && hit;
    assign w_push_req  = w_wr && (w_sel == C_SEL_TXDATA);
    assign w_ovf_clr   = w_wr && (w_sel == C_SEL_STATUS) && wd[3];
    assign w_ctrl_wr   = w_wr && (w_sel == C_SEL_CTRL);

    assign w_full      = (r_count == C_FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_can_pop   = r_enable && !w_empty;
    assign w_baud_done = (r_baud == C_BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_count4    = 4'(r_count);

    // A pop in the same cycle frees the slot the full-FIFO push lands in.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_set   = w_push_req && w_full && !w_pop;

    assign w_unused    = ^{wd[31:8], ra[1:0]};

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_shift_next = r_shift;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (w_can_pop) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_tx_next    = 1'b0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next   = r_bit_idx + 3'd1;
                        w_tx_next    = r_shift[0];
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (w_can_pop) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_tx_next    = 1'b0;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_tx_next;
            r_shift   <= w_shift_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_enable   <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A fresh overflow wins over a simultaneous clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_enable <= wd[0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wd[7:0];
        end
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (w_sel)
                C_SEL_STATUS: rd = {24'd0, w_count4, r_overflow, w_empty, w_full, w_busy};
                C_SEL_CTRL:   rd = {31'd0, r_enable};
                default:      rd = '0;
            endcase
        end
    end

    assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Directed/randomized bench for mmio_uart_tx against a frame-level
//            reference model (byte queue, ideal 8N1 waveform).
// Revision : 1.0
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [31:0] ra    = BASE + 32'd4;
    logic [31:0] wd    = '0;
    logic [31:0] rd;
    logic        hit;
    logic        tx;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .we   (we),
        .ra   (ra),
        .wd   (wd),
        .rd   (rd),
        .hit  (hit),
        .tx   (tx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Line monitor: every tx falling edge opens a frame of FRAME samples.
    logic [39:0] fr_bits_q [$];
    int          fr_t0_q   [$];
    logic [31:0] fr_st_q   [$];
    logic        mon_prev = 1'b1;
    logic [39:0] mon_bits;
    int          mon_t0;
    logic [31:0] mon_st;

    initial forever begin
        @(posedge clock);
        #2;
        if (mon_prev === 1'b1 && tx === 1'b0) begin
            mon_t0      = cyc;
            mon_st      = rd;
            mon_bits    = '0;
            mon_bits[0] = tx;
            for (int k = 1; k < FRAME; k++) begin
                @(posedge clock);
                #2;
                mon_bits[k] = tx;
            end
            fr_bits_q.push_back(mon_bits);
            fr_t0_q.push_back(mon_t0);
            fr_st_q.push_back(mon_st);
        end
        mon_prev = tx;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] frame_of(input logic [7:0] b);
        logic [9:0]  sym;
        logic [39:0] w;
        sym = {1'b1, b, 1'b0};
        for (int i = 0; i < FRAME; i++) w[i] = sym[i / CPB];
        return w;
    endfunction

    function automatic logic [31:0] exp_status(input logic busy, input int count, input logic ovf);
        return {24'd0, 4'(count), ovf, (count == 0), (count == DEPTH), busy};
    endfunction

    task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        we = 1'b1;
        ra = addr;
        wd = data;
        @(posedge clock);
        #1;
        we = 1'b0;
        ra = BASE + 32'd4;
        wd = '0;
    endtask

    task automatic mmio_read(input logic [31:0] addr, output logic [31:0] d);
        @(negedge clock);
        ra = addr;
        #1;
        d  = rd;
        ra = BASE + 32'd4;
    endtask

    task automatic get_frame(output logic [39:0] bits, output int t0, output logic [31:0] st);
        int n;
        n = 0;
        while (fr_bits_q.size() == 0 && n < 300) begin
            @(posedge clock);
            #3;
            n++;
        end
        check("frame_arrived", 64'(fr_bits_q.size() != 0), 64'h1);
        if (fr_bits_q.size() != 0) begin
            bits = fr_bits_q.pop_front();
            t0   = fr_t0_q.pop_front();
            st   = fr_st_q.pop_front();
        end else begin
            bits = '0;
            t0   = -1;
            st   = '0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [39:0] bits;
        logic [31:0] st;
        logic [7:0]  b;
        logic [7:0]  model_q [$];
        logic        model_ovf;
        int          t0, tprev, tw;

        // Reset and register map
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_tx", 64'(tx), 64'h1);
        mmio_read(BASE + 32'd4, d);  check("reset_status", 64'(d), 64'h4);
        mmio_read(BASE + 32'd8, d);  check("reset_ctrl", 64'(d), 64'h1);
        mmio_read(BASE + 32'd0, d);  check("txdata_reads_zero", 64'(d), 64'h0);
        mmio_read(BASE + 32'd12, d); check("reg3_reads_zero", 64'(d), 64'h0);
        @(negedge clock);
        ra = BASE + 32'h10;       #1; check("hit_above_window", 64'(hit), 64'h0);
        ra = BASE - 32'd1;        #1; check("hit_below_window", 64'(hit), 64'h0);
        ra = BASE + 32'h0F;       #1; check("hit_inside_window", 64'(hit), 64'h1);
        ra = BASE + 32'd4;
        mmio_write(BASE + 32'h10, 32'h0000_00AA);
        mmio_write(BASE + 32'd12, 32'hFFFF_FFFF);
        mmio_read(BASE + 32'd4, d); check("outside_write_ignored", 64'(d), 64'h4);
        mmio_read(BASE + 32'd8, d); check("reg3_write_ignored", 64'(d), 64'h1);

        // Single byte
        mmio_write(BASE, 32'h0000_00A5);
        tw = cyc;
        get_frame(bits, t0, st);
        check("single_latency", 64'(t0 - tw), 64'h1);
        check("single_frame", 64'(bits), 64'(frame_of(8'hA5)));
        check("single_status_at_start", 64'(st), 64'(exp_status(1'b1, 0, 1'b0)));
        @(posedge clock);
        mmio_read(BASE + 32'd4, d); check("single_idle_after", 64'(d), 64'h4);

        // Back-to-back, fixed then random
        mmio_write(BASE, 32'h0000_0055);
        tw = cyc;
        mmio_write(BASE, 32'h0000_000F);
        get_frame(bits, t0, st);
        check("b2b_latency", 64'(t0 - tw), 64'h1);
        check("b2b_frame0", 64'(bits), 64'(frame_of(8'h55)));
        tprev = t0;
        get_frame(bits, t0, st);
        check("b2b_frame1", 64'(bits), 64'(frame_of(8'h0F)));
        check("b2b_gap", 64'(t0 - tprev), 64'(FRAME));
        repeat (5) @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            model_q.push_back(b);
            mmio_write(BASE, {24'd0, b});
        end
        for (int i = 0; i < 3; i++) begin
            get_frame(bits, t0, st);
            check("rand_frame", 64'(bits), 64'(frame_of(model_q.pop_front())));
            if (i > 0) check("rand_gap", 64'(t0 - tprev), 64'(FRAME));
            tprev = t0;
        end
        repeat (5) @(posedge clock);

        // Overflow with transmitter disabled
        mmio_write(BASE + 32'd8, 32'h0);
        model_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else model_ovf = 1'b1;
            mmio_write(BASE, {24'd0, b});
        end
        mmio_read(BASE + 32'd4, d);
        check("ovf_status", 64'(d), 64'(exp_status(1'b0, model_q.size(), model_ovf)));
        mmio_write(BASE + 32'd4, 32'hFFFF_FFF7);
        mmio_read(BASE + 32'd4, d);
        check("status_write_no_w1c", 64'(d), 64'(exp_status(1'b0, model_q.size(), model_ovf)));
        mmio_write(BASE + 32'd4, 32'h0000_0008);
        model_ovf = 1'b0;
        mmio_read(BASE + 32'd4, d);
        check("ovf_cleared", 64'(d), 64'(exp_status(1'b0, model_q.size(), model_ovf)));
        mmio_read(BASE + 32'd8, d);
        check("ctrl_disabled", 64'(d), 64'h0);
        check("disabled_no_frame", 64'(fr_bits_q.size()), 64'h0);
        mmio_write(BASE + 32'd8, 32'h1);
        tw = cyc;
        for (int i = 0; i < DEPTH; i++) begin
            get_frame(bits, t0, st);
            check("ovf_drain_frame", 64'(bits), 64'(frame_of(model_q.pop_front())));
            if (i == 0) check("enable_latency", 64'(t0 - tw), 64'h1);
            else check("ovf_drain_gap", 64'(t0 - tprev), 64'(FRAME));
            tprev = t0;
        end
        repeat (5) @(posedge clock);
        mmio_read(BASE + 32'd4, d); check("drained_status", 64'(d), 64'h4);

        // Disable during data bit 3 with two bytes still queued
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            model_q.push_back(b);
            mmio_write(BASE, {24'd0, b});
            if (i == 0) tw = cyc;
        end
        while (cyc < tw + 18) begin
            @(posedge clock);
            #1;
        end
        mmio_write(BASE + 32'd8, 32'h0);
        get_frame(bits, t0, st);
        check("disable_frame_completes", 64'(bits), 64'(frame_of(model_q.pop_front())));
        repeat (60) @(posedge clock);
        check("disable_no_more_frames", 64'(fr_bits_q.size()), 64'h0);
        check("disable_tx_idle", 64'(tx), 64'h1);
        mmio_read(BASE + 32'd4, d);
        check("disable_fifo_retained", 64'(d), 64'(exp_status(1'b0, model_q.size(), 1'b0)));
        mmio_write(BASE + 32'd8, 32'h1);
        for (int i = 0; i < 2; i++) begin
            get_frame(bits, t0, st);
            check("reenable_frame", 64'(bits), 64'(frame_of(model_q.pop_front())));
            if (i > 0) check("reenable_gap", 64'(t0 - tprev), 64'(FRAME));
            tprev = t0;
        end
        repeat (5) @(posedge clock);

        // Reset during DATA with three bytes queued
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            mmio_write(BASE, {24'd0, b});
            if (i == 0) tw = cyc;
        end
        while (cyc < tw + 13) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("reset_mid_tx", 64'(tx), 64'h1);
        reset = 1'b0;
        mmio_read(BASE + 32'd4, d); check("reset_mid_status", 64'(d), 64'h4);
        mmio_read(BASE + 32'd8, d); check("reset_mid_ctrl", 64'(d), 64'h1);
        repeat (60) @(posedge clock);
        fr_bits_q.delete();
        fr_t0_q.delete();
        fr_st_q.delete();
        repeat (80) @(posedge clock);
        check("reset_mid_no_frames", 64'(fr_bits_q.size()), 64'h0);
        check("reset_mid_tx_idle", 64'(tx), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
